// File: rtl/byte_negate_serial.sv
// byte_negate_serial: bit-serial two's-complement negate / absolute value.
// One operand is processed LSB-first over WIDTH cycles using the
// "copy through the first 1, invert everything above it" rule.
module byte_negate_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             abs_mode,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             neg_en;    // operand is to be negated
  logic             seen_one;  // a 1 has already passed through
  logic             low_zero;  // every bit below the MSB was 0 so far
  logic             accept;
  logic             b, r, last;

  assign b    = shreg[0];
  assign r    = (neg_en & seen_one) ? ~b : b;
  assign last = (cnt == CW'(WIDTH-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid & !rst;
        if (accept) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Serial datapath; results are latched only on the SHIFT->DONE step so
  // out_data/out_ovf stay frozen for the whole DONE stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      neg_en   <= 1'b0;
      seen_one <= 1'b0;
      low_zero <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      shreg    <= in_data;
      neg_en   <= !abs_mode | in_data[WIDTH-1];
      seen_one <= 1'b0;
      low_zero <= 1'b1;
      cnt      <= '0;
    end else if (state == SHIFT) begin
      shreg    <= {r, shreg[WIDTH-1:1]};
      seen_one <= seen_one | b;
      cnt      <= cnt + CW'(1);
      if (!last) low_zero <= low_zero & ~b;
      if (last) begin
        out_data <= {r, shreg[WIDTH-1:1]};
        // only the most negative value has no positive counterpart
        out_ovf  <= neg_en & low_zero & b;
      end
    end
  end

endmodule

// File: tb/tb_byte_negate_serial.sv
// Directed bench for byte_negate_serial.
module tb_byte_negate_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       abs_mode;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  byte_negate_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .abs_mode(abs_mode), .in_ready(in_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives one operand and returns the observed result and latency
  // (negedges after the accepting edge until out_valid is seen).
  task automatic do_op(input logic [7:0] d, input logic am,
                       output logic [7:0] res, output logic ov,
                       output int lat, output bit ok);
    int w;
    ok = 1'b0; lat = 0; res = '0; ov = 1'b0;
    @(negedge clk);
    in_data = d; abs_mode = am; in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!out_valid) return;
    res = out_data; ov = out_ovf; ok = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; abs_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_ovf, in_ready} !== 11'b0) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%h o=%b r=%b, want all 0",
               out_valid, out_data, out_ovf, in_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors(input logic am);
    logic [7:0] vin[6], vexp[6];
    logic       vovf[6];
    logic [7:0] res; logic ov; int lat; bit ok; int n;
    if (!am) begin
      vin  = '{8'h01, 8'h00, 8'h7F, 8'h20, 8'hFF, 8'h80};
      vexp = '{8'hFF, 8'h00, 8'h81, 8'hE0, 8'h01, 8'h80};
      vovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n = 6;
    end else begin
      vin  = '{8'hFF, 8'h20, 8'h80, 8'h00, 8'h00, 8'h00};
      vexp = '{8'h01, 8'h20, 8'h80, 8'h00, 8'h00, 8'h00};
      vovf = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      n = 4;
    end
    for (int i = 0; i < n; i++) begin
      do_op(vin[i], am, res, ov, lat, ok);
      tests++;
      if (!ok) begin
        fails++; $display("FAIL op_timeout abs=%b in=%h", am, vin[i]);
        continue;
      end
      tests++;
      if (res !== vexp[i] || ov !== vovf[i]) begin
        fails++;
        $display("FAIL result abs=%b in=%h: got %h ovf=%b, want %h ovf=%b",
                 am, vin[i], res, ov, vexp[i], vovf[i]);
      end
      tests++;
      if (lat !== 8) begin
        fails++; $display("FAIL latency abs=%b in=%h: got %0d want 8", am, vin[i], lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int w; bit bad_v, bad_d, bad_r, seen;
    @(negedge clk);
    out_ready = 1'b0; in_data = 8'h05; abs_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin @(negedge clk); w++; end
    tests++;
    if (!out_valid) begin fails++; $display("FAIL bp_timeout: out_valid never rose"); end
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin in_data = 8'h33; in_valid = 1'b1; end
      if (i == 6) in_valid = 1'b0;
      if (out_valid !== 1'b1) bad_v = 1;
      if (out_data !== 8'hFB || out_ovf !== 1'b0) bad_d = 1;
      if (in_ready !== 1'b0) bad_r = 1;
      @(negedge clk);
    end
    tests++;
    if (bad_v) begin fails++; $display("FAIL bp_valid_hold: got dropped want 1"); end
    tests++;
    if (bad_d) begin fails++; $display("FAIL bp_data_hold: got %h want fb", out_data); end
    tests++;
    if (bad_r) begin fails++; $display("FAIL bp_ready_low: got 1 want 0"); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL bp_stall_capture: got out_valid=1 want none"); end
  endtask

  task automatic test_back_to_back();
    int t, nacc, nres;
    int acc_t[2];
    logic [7:0] rs[2];
    @(negedge clk);
    in_data = 8'h01; abs_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    t = 0; nacc = 0; nres = 0; acc_t = '{0, 0}; rs = '{8'h00, 8'h00};
    while (t < 40 && (nres < 2 || nacc < 2)) begin
      if (nacc == 1) in_data = 8'h02;
      if (nacc == 2) in_valid = 1'b0;
      if (out_valid && nres < 2) begin rs[nres] = out_data; nres++; end
      if (in_valid && in_ready && nacc < 2) begin acc_t[nacc] = t; nacc++; end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    tests++;
    if (nacc != 2 || nres != 2) begin
      fails++; $display("FAIL b2b_timeout: got acc=%0d res=%0d want 2/2", nacc, nres);
    end
    tests++;
    if (rs[0] !== 8'hFF || rs[1] !== 8'hFE) begin
      fails++; $display("FAIL b2b_results: got %h %h want ff fe", rs[0], rs[1]);
    end
    tests++;
    if (acc_t[1] - acc_t[0] != 10) begin
      fails++; $display("FAIL b2b_spacing: got %0d want 10", acc_t[1] - acc_t[0]);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen; logic [7:0] res; logic ov; int lat; bit ok;
    @(negedge clk);
    in_data = 8'h7F; abs_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_ovf, in_ready} !== 11'b0) begin
      fails++;
      $display("FAIL midrst_state: got v=%b d=%h o=%b r=%b want all 0",
               out_valid, out_data, out_ovf, in_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL midrst_partial: got out_valid=1 want none"); end
    do_op(8'h03, 1'b0, res, ov, lat, ok);
    tests++;
    if (!ok || res !== 8'hFD || ov !== 1'b0) begin
      fails++; $display("FAIL midrst_next: got ok=%b %h ovf=%b want fd ovf=0", ok, res, ov);
    end
  endtask

  task automatic test_reset_with_valid();
    bit seen;
    @(negedge clk);
    rst = 1'b1; in_data = 8'h10; abs_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL rstvalid_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1; end
    tests++;
    if (seen || in_ready !== 1'b1) begin
      fails++; $display("FAIL rstvalid_capture: got valid_seen=%b ready=%b want 0/1", seen, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_vectors(1'b0);
    test_vectors(1'b1);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_reset_with_valid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
